// File: rtl/alu_4bit.sv
// rtl/alu_4bit.sv - 4-bit cascadable ALU slice (AND/OR/ADD/SUB/SLT) with lookahead group outputs
// Registered result/cout/overflow/zero; g, p and set are combinational.
module alu_4bit (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  input  logic       less_i,
  input  logic [2:0] op_i,
  output logic [3:0] result_o,
  output logic       cout_o,
  output logic       g_o,
  output logic       p_o,
  output logic       set_o,
  output logic       overflow_o,
  output logic       zero_o
);

  logic [3:0] bb;
  logic [3:0] gi;
  logic [3:0] pi;
  logic       c1, c2, c3, c4;
  logic [3:0] sum;
  logic       ovf_n;

  logic [3:0] result_d, result_q;
  logic       cout_q, overflow_q, zero_q;
  logic       zero_d;

  assign bb = op_i[2] ? ~b_i : b_i;
  assign gi = a_i & bb;
  assign pi = a_i | bb;

  // Carries are flattened lookahead terms so the group outputs and c4 share logic.
  assign c1 = gi[0] | (pi[0] & cin_i);
  assign c2 = gi[1] | (pi[1] & gi[0]) | (pi[1] & pi[0] & cin_i);
  assign c3 = gi[2] | (pi[2] & gi[1]) | (pi[2] & pi[1] & gi[0])
            | (pi[2] & pi[1] & pi[0] & cin_i);

  assign g_o = gi[3] | (pi[3] & gi[2]) | (pi[3] & pi[2] & gi[1])
             | (pi[3] & pi[2] & pi[1] & gi[0]);
  assign p_o = &pi;
  assign c4  = g_o | (p_o & cin_i);

  assign sum   = a_i ^ bb ^ {c3, c2, c1, cin_i};
  assign ovf_n = c3 ^ c4;
  // set is independent of less_i so an external set->less loop stays acyclic.
  assign set_o = sum[3] ^ ovf_n;

  always_comb begin
    result_d = 4'b0000;
    unique case (op_i[1:0])
      2'b00:   result_d = a_i & bb;
      2'b01:   result_d = a_i | bb;
      2'b10:   result_d = sum;
      2'b11:   result_d = {3'b000, less_i};
      default: result_d = 4'b0000;
    endcase
  end

  assign zero_d = (result_d == 4'b0000);

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q   <= 4'b0000;
      cout_q     <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b1;
    end else begin
      result_q   <= result_d;
      cout_q     <= c4;
      overflow_q <= ovf_n;
      zero_q     <= zero_d;
    end
  end

  assign result_o   = result_q;
  assign cout_o     = cout_q;
  assign overflow_o = overflow_q;
  assign zero_o     = zero_q;

endmodule

// File: tb/tb_alu_4bit.sv
// tb/tb_alu_4bit.sv - randomized and directed self-checking bench for alu_4bit
// Expected values come from signed/unsigned integer arithmetic on the operands.
module tb_alu_4bit;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] a_i, b_i;
  logic       cin_i, less_i;
  logic [2:0] op_i;
  logic [3:0] result_o;
  logic       cout_o, g_o, p_o, set_o, overflow_o, zero_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_4bit dut (
    .clk        (clk),
    .rst        (rst),
    .a_i        (a_i),
    .b_i        (b_i),
    .cin_i      (cin_i),
    .less_i     (less_i),
    .op_i       (op_i),
    .result_o   (result_o),
    .cout_o     (cout_o),
    .g_o        (g_o),
    .p_o        (p_o),
    .set_o      (set_o),
    .overflow_o (overflow_o),
    .zero_o     (zero_o)
  );

  typedef struct {
    int res;
    int cout;
    int ovf;
    int zero;
    int g;
    int p;
    int set;
  } exp_t;

  typedef struct {
    int a;
    int b;
    int op;
    int cin;
  } vec_t;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input int a, input int b, input int op, input int cin,
                                 input int less);
    exp_t e;
    int bb, su, sa, sb, t;
    bb = ((op / 4) % 2 == 1) ? 15 - b : b;
    su = a + bb + cin;
    sa = (a >= 8) ? a - 16 : a;
    sb = (bb >= 8) ? bb - 16 : bb;
    t  = sa + sb + cin;
    e.cout = (su >= 16) ? 1 : 0;
    e.ovf  = (t > 7 || t < -8) ? 1 : 0;
    e.set  = (t < 0) ? 1 : 0;
    e.p    = ((a | bb) == 15) ? 1 : 0;
    e.g    = (a + bb >= 16) ? 1 : 0;
    case (op % 4)
      0:       e.res = a & bb;
      1:       e.res = a | bb;
      2:       e.res = su % 16;
      default: e.res = less;
    endcase
    e.zero = (e.res == 0) ? 1 : 0;
    return e;
  endfunction

  // Drives one operation after a falling edge, checks combinational outputs
  // before the rising edge and registered outputs just after it.
  task automatic apply(input int a, input int b, input int op, input int cin,
                       input int less, input bit use_set, input bit do_rst);
    exp_t e;
    @(negedge clk);
    rst   = do_rst;
    a_i   = 4'(a);
    b_i   = 4'(b);
    op_i  = 3'(op);
    cin_i = 1'(cin);
    e = model(a, b, op, cin, 0);
    if (use_set) less = e.set;
    less_i = 1'(less);
    e = model(a, b, op, cin, less);
    #1;
    chk("g",   int'(g_o),   e.g);
    chk("p",   int'(p_o),   e.p);
    chk("set", int'(set_o), e.set);
    @(posedge clk);
    #1;
    if (do_rst) begin
      e.res = 0; e.cout = 0; e.ovf = 0; e.zero = 1;
    end
    chk(do_rst ? "rst_result" : "result",   int'(result_o),   e.res);
    chk(do_rst ? "rst_cout"   : "cout",     int'(cout_o),     e.cout);
    chk(do_rst ? "rst_ovf"    : "overflow", int'(overflow_o), e.ovf);
    chk(do_rst ? "rst_zero"   : "zero",     int'(zero_o),     e.zero);
  endtask

  vec_t dir[$];

  initial begin
    rst = 1'b1; a_i = 4'h0; b_i = 4'h0; cin_i = 1'b0; less_i = 1'b0; op_i = 3'b000;

    apply(4'hF, 4'hA, 3'b010, 0, 1, 1'b0, 1'b1);
    apply(4'h8, 4'h8, 3'b111, 1, 1, 1'b0, 1'b1);

    dir.push_back('{15, 2, 4, 1});
    dir.push_back('{7, 7, 2, 0});
    dir.push_back('{8, 8, 2, 0});
    dir.push_back('{9, 7, 2, 0});
    dir.push_back('{7, 7, 6, 1});
    dir.push_back('{9, 7, 6, 1});
    dir.push_back('{9, 9, 6, 1});
    dir.push_back('{8, 1, 6, 1});
    dir.push_back('{0, 1, 7, 1});
    dir.push_back('{1, 0, 7, 1});
    dir.push_back('{9, 15, 7, 1});
    dir.push_back('{15, 9, 7, 1});
    dir.push_back('{15, 0, 7, 1});
    dir.push_back('{8, 1, 3, 0});
    dir.push_back('{8, 0, 3, 0});
    dir.push_back('{5, 10, 2, 0});
    dir.push_back('{5, 10, 2, 1});
    dir.push_back('{15, 15, 0, 0});
    dir.push_back('{12, 10, 1, 0});
    foreach (dir[i]) apply(dir[i].a, dir[i].b, dir[i].op, dir[i].cin, 0, 1'b1, 1'b0);

    for (int i = 0; i < 400; i++) begin
      int op, cin;
      op  = int'($urandom_range(0, 7));
      cin = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1)) : op / 4;
      apply(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), op, cin,
            int'($urandom_range(0, 1)), $urandom_range(0, 1) == 1,
            $urandom_range(0, 15) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
